// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive-side FIFO and its timeout tracker.
package uart_rx_fifo_pkg;

  localparam int unsigned UART_FIFO_DEPTH  = 16;
  localparam int unsigned UART_FIFO_ADDR_W = 4;
  localparam int unsigned UART_FIFO_THRESH = 8;
  localparam logic [15:0] UART_RX_TMO_CYC  = 16'd4340;

  typedef logic [UART_FIFO_ADDR_W-1:0] uart_fifo_addr_t;
  typedef logic [UART_FIFO_ADDR_W:0]   uart_fifo_cnt_t;

  typedef enum logic [1:0] {
    UART_FIFO_TMO_IDLE,
    UART_FIFO_TMO_ARMED,
    UART_FIFO_TMO_FIRED
  } uart_fifo_tmo_e;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x 8 register file: synchronous write port, asynchronous read port.
module uart_fifo_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: circular first-word-fall-through FIFO with sticky overrun,
// fill-threshold / idle-timeout level interrupt.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH   = UART_FIFO_DEPTH,
  parameter int unsigned ADDR_W  = UART_FIFO_ADDR_W,
  parameter int unsigned THRESH  = UART_FIFO_THRESH,
  parameter logic [15:0] TMO_CYC = UART_RX_TMO_CYC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx_end,
  input  logic [7:0]      rx_data,
  input  logic            rd_en,
  output logic [7:0]      rd_data,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overrun,
  input  logic            ovr_clr,
  output logic            irq
);

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_C = (ADDR_W+1)'(THRESH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overrun_q, overrun_d;
  logic              irq_q, irq_d;
  uart_fifo_tmo_e    tmo_state_q, tmo_state_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;

  logic rd_acc;
  logic wr_acc;
  logic tmo_flag;

  // A pop on a full FIFO frees the slot the incoming byte lands in, so the write is accepted.
  assign rd_acc   = rd_en & ~empty_q;
  assign wr_acc   = rx_end & (~full_q | rd_acc);
  assign tmo_flag = (tmo_state_q == UART_FIFO_TMO_FIRED);

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr_q),
    .wr_data(rx_data),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == DEPTH_C);

    // Set takes priority over clear when both land in the same cycle.
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (rx_end && full_q && !rd_acc) begin
      overrun_d = 1'b1;
    end

    irq_d = (count_q >= THRESH_C) | tmo_flag;
  end

  always_comb begin
    tmo_state_d = tmo_state_q;
    tmo_cnt_d   = tmo_cnt_q;

    unique case (tmo_state_q)
      UART_FIFO_TMO_IDLE: begin
        if (wr_acc) begin
          tmo_state_d = UART_FIFO_TMO_ARMED;
          tmo_cnt_d   = '0;
        end
      end
      UART_FIFO_TMO_ARMED: begin
        if (wr_acc) begin
          tmo_cnt_d = '0;
        end else if (count_d == '0) begin
          tmo_state_d = UART_FIFO_TMO_IDLE;
        end else if (tmo_cnt_q == TMO_CYC - 16'd1) begin
          tmo_state_d = UART_FIFO_TMO_FIRED;
        end else if (tmo_cnt_q != '1) begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      UART_FIFO_TMO_FIRED: begin
        if (wr_acc) begin
          tmo_state_d = UART_FIFO_TMO_ARMED;
          tmo_cnt_d   = '0;
        end else if (count_d == '0) begin
          tmo_state_d = UART_FIFO_TMO_IDLE;
        end
      end
      default: begin
        tmo_state_d = UART_FIFO_TMO_IDLE;
        tmo_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
      tmo_state_q <= UART_FIFO_TMO_IDLE;
      tmo_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      overrun_q   <= overrun_d;
      irq_q       <= irq_d;
      tmo_state_q <= tmo_state_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign overrun = overrun_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: vector table plus hand-written corner sequences.
module tb_uart_rx_fifo;
  import uart_rx_fifo_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TMO   = 4340;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_end;
  logic [7:0] rx_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;
  logic       irq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (4),
    .THRESH (8),
    .TMO_CYC(16'd4340)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx_end (rx_end),
    .rx_data(rx_data),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .empty  (empty),
    .full   (full),
    .count  (count),
    .overrun(overrun),
    .ovr_clr(ovr_clr),
    .irq    (irq)
  );

  typedef struct {
    logic       rx_end;
    logic [7:0] rx_data;
    logic       rd_en;
    logic [4:0] e_count;
    logic       e_empty;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    rx_end  = 1'b1;
    rx_data = b;
    step();
    rx_end  = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  vec_t       vecs [11];
  logic [7:0] exp_q [$];

  initial begin
    reset   = 1'b0;
    rx_end  = 1'b0;
    rx_data = '0;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
    step();
    step();
    chk("reset count", count, 0);
    chk("reset empty", empty, 1);
    chk("reset full", full, 0);
    chk("reset overrun", overrun, 0);
    chk("reset irq", irq, 0);
    reset = 1'b1;

    // Basic ordering, pop-on-empty, and simultaneous push/pop cases.
    vecs[0]  = '{1'b1, 8'h41, 1'b0, 5'd1, 1'b0, 1'b1, 8'h41};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b1, 8'h41};
    vecs[2]  = '{1'b1, 8'h42, 1'b0, 5'd2, 1'b0, 1'b1, 8'h41};
    vecs[3]  = '{1'b1, 8'h43, 1'b0, 5'd3, 1'b0, 1'b1, 8'h41};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b1, 8'h42};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b1, 8'h43};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 8'h7E, 1'b1, 5'd1, 1'b0, 1'b1, 8'h7E};
    vecs[9]  = '{1'b1, 8'h11, 1'b1, 5'd1, 1'b0, 1'b1, 8'h11};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h00};

    for (int i = 0; i < 11; i++) begin
      rx_end  = vecs[i].rx_end;
      rx_data = vecs[i].rx_data;
      rd_en   = vecs[i].rd_en;
      step();
      rx_end = 1'b0;
      rd_en  = 1'b0;
      chk($sformatf("vec%0d count", i), count, vecs[i].e_count);
      chk($sformatf("vec%0d empty", i), empty, vecs[i].e_empty);
      chk($sformatf("vec%0d full", i), full, 0);
      chk($sformatf("vec%0d irq", i), irq, 0);
      if (vecs[i].chk_data) chk($sformatf("vec%0d rd_data", i), rd_data, vecs[i].e_data);
    end

    // Fill to full, then overflow with 0xAA; threshold irq along the way.
    for (int i = 0; i < 16; i++) begin
      write_byte(8'(i));
      if (i == 7) chk("thr irq not yet", irq, 0);
      if (i == 8) chk("thr irq set", irq, 1);
    end
    chk("fill full", full, 1);
    chk("fill count", count, 16);
    write_byte(8'hAA);
    chk("ovf overrun", overrun, 1);
    chk("ovf count", count, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain1 data%0d", i), rd_data, 32'(i));
      pop();
    end
    chk("drain1 empty", empty, 1);

    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr cleared", overrun, 0);

    // Full FIFO with simultaneous push and pop, then overrun set racing ovr_clr.
    for (int i = 0; i < 16; i++) write_byte(8'(8'h20 + i));
    rx_end  = 1'b1;
    rx_data = 8'h55;
    rd_en   = 1'b1;
    step();
    rx_end = 1'b0;
    rd_en  = 1'b0;
    chk("full rw count", count, 16);
    chk("full rw overrun", overrun, 0);
    chk("full rw full", full, 1);
    rx_end  = 1'b1;
    rx_data = 8'h99;
    ovr_clr = 1'b1;
    step();
    rx_end  = 1'b0;
    ovr_clr = 1'b0;
    chk("set beats clr", overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("clr alone", overrun, 0);
    exp_q.delete();
    for (int i = 1; i < 16; i++) exp_q.push_back(8'(8'h20 + i));
    exp_q.push_back(8'h55);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain2 data%0d", i), rd_data, 32'(exp_q[i]));
      pop();
    end
    chk("drain2 empty", empty, 1);
    step();
    chk("drain2 irq", irq, 0);

    // Threshold irq drop after one pop, then reset mid-stream.
    for (int i = 0; i < 8; i++) write_byte(8'(8'h80 + i));
    chk("thr8 irq lag", irq, 0);
    step();
    chk("thr8 irq", irq, 1);
    pop();
    chk("thr7 count", count, 7);
    chk("thr7 irq lag", irq, 1);
    step();
    chk("thr7 irq", irq, 0);
    reset   = 1'b0;
    rx_end  = 1'b1;
    rx_data = 8'hEE;
    step();
    reset  = 1'b1;
    rx_end = 1'b0;
    chk("midrst count", count, 0);
    chk("midrst empty", empty, 1);
    chk("midrst irq", irq, 0);
    step();
    chk("midrst hold", count, 0);

    // Idle timeout: fire, restart on write, clear on drain.
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    for (int k = 0; k < TMO - 1; k++) step();
    chk("tmo early", irq, 0);
    step();
    step();
    chk("tmo fired", irq, 1);
    write_byte(8'h04);
    step();
    chk("tmo rewrite clr", irq, 0);
    for (int k = 0; k < TMO - 2; k++) step();
    chk("tmo restart early", irq, 0);
    step();
    step();
    chk("tmo refired", irq, 1);
    for (int i = 0; i < 4; i++) pop();
    chk("tmo drain empty", empty, 1);
    step();
    chk("tmo drain irq", irq, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
